// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state/light encodings and index-width helper for the traffic controller
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_FLASH   = 3'd3
    } tlc_state_e;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;
    localparam logic [1:0] LT_FLASH  = 2'b11;

    // Width of an approach index; never below one bit so ports stay legal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// rtl/tlc_rr_arbiter.sv - combinational two-level (long queue over short queue) round-robin finder
module tlc_rr_arbiter
    import tlc_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int RECALL_IDX = 0,
    parameter int IDX_W      = idx_w(N_APPROACH)
) (
    input  logic [N_APPROACH-1:0] S1,
    input  logic [N_APPROACH-1:0] S5,
    input  logic [IDX_W-1:0]      start_idx,
    output logic [IDX_W-1:0]      winner,
    output logic                  valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_APPROACH - 1);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win_s5;
    logic [IDX_W-1:0] win_dem;
    logic             found_s5;
    logic             found_dem;

    // Walk every approach once from start_idx; the first long queue beats the first plain demand.
    always_comb begin
        idx       = start_idx;
        win_s5    = '0;
        win_dem   = '0;
        found_s5  = 1'b0;
        found_dem = 1'b0;
        for (int k = 0; k < N_APPROACH; k++) begin
            if (!found_s5 && S5[idx]) begin
                found_s5 = 1'b1;
                win_s5   = idx;
            end
            if (!found_dem && (S1[idx] || S5[idx])) begin
                found_dem = 1'b1;
                win_dem   = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        valid  = found_dem;
        winner = found_s5  ? win_s5  :
                 found_dem ? win_dem : IDX_W'(RECALL_IDX);
    end

endmodule

// File: rtl/adaptive_tlc_multiway.sv
// rtl/adaptive_tlc_multiway.sv - adaptive N-approach intersection FSM with recall and flash modes
module adaptive_tlc_multiway
    import tlc_pkg::*;
#(
    parameter int N_APPROACH  = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 4,
    parameter int T_MAX_GREEN = 12,
    parameter int T_MAX_LONG  = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int RECALL_IDX  = 0,
    localparam int IDX_W      = idx_w(N_APPROACH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_APPROACH-1:0]   S1,
    input  logic [N_APPROACH-1:0]   S5,
    input  logic                    flash_req,
    output logic [2:0]              current_state,
    output logic [IDX_W-1:0]        active_idx,
    output logic [2*N_APPROACH-1:0] lights,
    output logic                    green_start
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_APPROACH - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAXG_LAST  = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_MAX_LONG - 1);
    localparam logic [CNT_W-1:0] TIMER_SAT  = '1;

    tlc_state_e              state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]        active_q, active_d;
    logic [2*N_APPROACH-1:0] lights_q, lights_d;
    logic                    green_start_q, green_start_d;

    logic [N_APPROACH-1:0]   demand;
    logic [N_APPROACH-1:0]   other_mask;
    logic                    other;
    logic [CNT_W-1:0]        tmax_last;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        arb_winner;
    logic                    arb_valid;

    // The search begins just after the current owner so the owner is considered last.
    assign start_idx = (active_q == LAST_IDX) ? '0 : active_q + 1'b1;

    tlc_rr_arbiter #(
        .N_APPROACH (N_APPROACH),
        .RECALL_IDX (RECALL_IDX),
        .IDX_W      (IDX_W)
    ) u_arb (
        .S1        (S1),
        .S5        (S5),
        .start_idx (start_idx),
        .winner    (arb_winner),
        .valid     (arb_valid)
    );

    // Demand on any approach other than the current owner, and the green ceiling for the owner.
    always_comb begin
        demand             = S1 | S5;
        other_mask         = demand;
        other_mask[active_q] = 1'b0;
        other              = |other_mask;
        tmax_last          = S5[active_q] ? LONG_LAST : MAXG_LAST;
    end

    // Next-state, phase exits and owner selection.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            ST_ALL_RED: begin
                if (timer_q == AR_LAST) begin
                    if (flash_req) begin
                        state_d = ST_FLASH;
                    end else begin
                        state_d  = ST_GREEN;
                        active_d = arb_valid ? arb_winner : IDX_W'(RECALL_IDX);
                    end
                end
            end
            ST_GREEN: begin
                if (flash_req) begin
                    state_d = ST_YELLOW;
                end else if ((timer_q >= MIN_LAST) && other &&
                             (!demand[active_q] || (timer_q >= tmax_last))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_FLASH: begin
                if (!flash_req) begin
                    state_d = ST_ALL_RED;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase
    end

    // Phase timer restarts on every state entry and saturates instead of wrapping.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TIMER_SAT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Lamp decode from the upcoming state so lamps and state change on the same edge.
    always_comb begin
        lights_d      = '0;
        green_start_d = (state_d == ST_GREEN) && (state_q != ST_GREEN);
        for (int i = 0; i < N_APPROACH; i++) begin
            if (state_d == ST_FLASH) begin
                lights_d[2*i +: 2] = LT_FLASH;
            end else if (IDX_W'(i) == active_d) begin
                if (state_d == ST_GREEN) begin
                    lights_d[2*i +: 2] = LT_GREEN;
                end else if (state_d == ST_YELLOW) begin
                    lights_d[2*i +: 2] = LT_YELLOW;
                end else begin
                    lights_d[2*i +: 2] = LT_RED;
                end
            end
        end
    end

    // State, timer, owner and registered outputs; reset forces all-red immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            active_q      <= LAST_IDX;
            lights_q      <= '0;
            green_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            active_q      <= active_d;
            lights_q      <= lights_d;
            green_start_q <= green_start_d;
        end
    end

    assign current_state = state_q;
    assign active_idx    = active_q;
    assign lights        = lights_q;
    assign green_start   = green_start_q;

endmodule
